// File: rtl/gpa_spi_serialiser_if.sv
// Staging-write/commit controls and SPI pins for gpa_spi_serialiser.
// The master side is the gradient memory core; the slave side is the serialiser.
interface gpa_spi_serialiser_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 24,
  parameter int DIV_W  = 6
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              wr_i;
  logic [CH_W-1:0]   ch_i;
  logic [DATA_W-1:0] data_i;
  logic              commit_i;
  logic [DIV_W-1:0]  div_i;
  logic              ldac_en_i;
  logic              clr_err_i;
  logic              sclk_o;
  logic              syncn_o;
  logic              ldacn_o;
  logic [N_CH-1:0]   sdo_o;
  logic              busy_o;
  logic              data_lost_o;
  logic              commit_lost_o;

  modport master (
    output wr_i, ch_i, data_i, commit_i, div_i, ldac_en_i, clr_err_i,
    input  sclk_o, syncn_o, ldacn_o, sdo_o, busy_o, data_lost_o, commit_lost_o
  );

  modport slave (
    input  wr_i, ch_i, data_i, commit_i, div_i, ldac_en_i, clr_err_i,
    output sclk_o, syncn_o, ldacn_o, sdo_o, busy_o, data_lost_o, commit_lost_o
  );
endinterface

// File: rtl/gpa_spi_serialiser.sv
// Multi-channel SPI serialiser: staged words shift out in parallel on shared SCLK/SYNC, then optional LDAC.
// SYNC falls 2 cycles after commit; no backpressure - writes always land, a busy commit queues (one deep).
module gpa_spi_serialiser #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 24,
  parameter int DIV_W  = 6,
  parameter int LDAC_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  gpa_spi_serialiser_if.slave  bus
);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int LD_W  = (LDAC_W > 1) ? $clog2(LDAC_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, LDAC} state_t;

  state_t            state;
  logic [DATA_W-1:0] staging  [N_CH];
  logic [DATA_W-1:0] sreg     [N_CH];
  logic [DATA_W-1:0] load_val [N_CH];
  logic [N_CH-1:0]   present;
  logic              pending;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W:0]    ph;
  logic [BIT_W-1:0]  bit_cnt;
  logic [LD_W-1:0]   ld_cnt;
  logic              sclk_q, syncn_q, ldacn_q;
  logic [N_CH-1:0]   sdo_q;
  logic              data_lost_q, commit_lost_q;
  logic              wr_ok, start;

  assign wr_ok = bus.wr_i && (int'(bus.ch_i) < N_CH);
  assign start = (state == IDLE) && (pending || bus.commit_i);

  // Same-cycle write bypasses staging so it lands in the frame being loaded.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      load_val[c] = (wr_ok && int'(bus.ch_i) == c) ? bus.data_i : staging[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= 1'b0;
      present       <= '0;
      div_q         <= '0;
      ph            <= '0;
      bit_cnt       <= '0;
      ld_cnt        <= '0;
      sclk_q        <= 1'b0;
      syncn_q       <= 1'b1;
      ldacn_q       <= 1'b1;
      sdo_q         <= '0;
      data_lost_q   <= 1'b0;
      commit_lost_q <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        staging[c] <= '0;
        sreg[c]    <= '0;
      end
    end else begin
      if (wr_ok) begin
        staging[bus.ch_i] <= bus.data_i;
        present[bus.ch_i] <= 1'b1;
      end

      // A new error event wins over a same-cycle clear.
      if (wr_ok && present[bus.ch_i]) data_lost_q <= 1'b1;
      else if (bus.clr_err_i)         data_lost_q <= 1'b0;
      if (bus.commit_i && pending)    commit_lost_q <= 1'b1;
      else if (bus.clr_err_i)         commit_lost_q <= 1'b0;

      if (start)             pending <= 1'b0;
      else if (bus.commit_i) pending <= 1'b1;

      case (state)
        IDLE: begin
          sclk_q  <= 1'b0;
          syncn_q <= 1'b1;
          ldacn_q <= 1'b1;
          if (start) begin
            for (int c = 0; c < N_CH; c++) sreg[c] <= load_val[c];
            present <= '0;
            div_q   <= bus.div_i;
            ph      <= '0;
            bit_cnt <= BIT_W'(DATA_W - 1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          syncn_q <= 1'b0;
          ldacn_q <= 1'b1;
          sclk_q  <= (ph > {1'b0, div_q});
          if (ph == '0) begin
            for (int c = 0; c < N_CH; c++) begin
              sdo_q[c] <= sreg[c][DATA_W-1];
              sreg[c]  <= {sreg[c][DATA_W-2:0], 1'b0};
            end
          end
          if (ph == {div_q, 1'b1}) begin
            ph <= '0;
            if (bit_cnt == '0) state <= GAP;
            else               bit_cnt <= bit_cnt - 1'b1;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        GAP: begin
          syncn_q <= 1'b1;
          sclk_q  <= 1'b0;
          sdo_q   <= '0;
          ld_cnt  <= '0;
          state   <= bus.ldac_en_i ? LDAC : IDLE;
        end
        LDAC: begin
          ldacn_q <= 1'b0;
          if (ld_cnt == LD_W'(LDAC_W - 1)) state <= IDLE;
          else                             ld_cnt <= ld_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk_o        = sclk_q;
  assign bus.syncn_o       = syncn_q;
  assign bus.ldacn_o       = ldacn_q;
  assign bus.sdo_o         = sdo_q;
  assign bus.busy_o        = (state != IDLE) || pending;
  assign bus.data_lost_o   = data_lost_q;
  assign bus.commit_lost_o = commit_lost_q;
endmodule

// File: tb/tb_gpa_spi_serialiser.sv
// Randomised and directed bench for gpa_spi_serialiser against a frame-timeline reference model.
module tb_gpa_spi_serialiser;
  localparam int N_CH = 4, DATA_W = 24, DIV_W = 6, LDAC_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gpa_spi_serialiser_if #(.N_CH(N_CH), .DATA_W(DATA_W), .DIV_W(DIV_W)) bus ();

  gpa_spi_serialiser #(.N_CH(N_CH), .DATA_W(DATA_W), .DIV_W(DIV_W), .LDAC_W(LDAC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0, errors = 0;
  logic [DIV_W-1:0] div = '0;
  bit ldac_en = 1'b0;

  // Reference model: staging state plus the timeline of the current frame.
  logic [DATA_W-1:0] m_stage [N_CH];
  logic [DATA_W-1:0] m_word  [N_CH];
  bit [N_CH-1:0] m_present;
  bit m_pending, m_dl, m_cl, m_have, m_ldac, m_rst_last;
  longint edge_n = 0, m_s, m_end;
  int m_d, m_L;

  // Observed-waveform monitor.
  bit prev_sync = 1, prev_sclk = 0, prev_ldac = 1;
  int lo_run = 0, hi_run = 100, ld_run = 0;
  int last_low = 0, last_gap = 0, last_ld = 0, frames = 0, ldac_pulses = 0, sclk_per = 0;
  longint t_fall = 0, t_rise = 0, t_sclk_rise = -1, gap_ldac = 0;
  logic [DATA_W-1:0] cap [N_CH];
  logic [DATA_W-1:0] last_word [N_CH];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", tag, edge_n, act, exp);
    end
  endtask

  function automatic bit model_busy();
    return (m_have && edge_n < m_end) || m_pending;
  endfunction

  function automatic void model_step(input bit wr, input int ch, input logic [DATA_W-1:0] data,
                                     input bit commit, input bit clr, input bit rst);
    bit idle, ev_dl, ev_cl;
    edge_n++;
    m_rst_last = rst;
    if (rst) begin
      for (int c = 0; c < N_CH; c++) m_stage[c] = '0;
      m_present = '0; m_pending = 0; m_dl = 0; m_cl = 0; m_have = 0;
      return;
    end
    idle  = !m_have || edge_n > m_end;
    ev_dl = 0;
    ev_cl = commit && m_pending;
    if (wr && ch < N_CH) begin
      ev_dl = m_present[ch];
      m_stage[ch] = data;
      m_present[ch] = 1;
    end
    if (idle && (m_pending || commit)) begin
      for (int c = 0; c < N_CH; c++) m_word[c] = m_stage[c];
      m_present = '0; m_pending = 0; m_have = 1;
      m_s = edge_n; m_d = int'(div); m_L = DATA_W * 2 * (m_d + 1); m_ldac = ldac_en;
      m_end = m_s + m_L + 1 + (m_ldac ? LDAC_W : 0);
    end else if (commit) begin
      m_pending = 1;
    end
    m_dl = (m_dl && !clr) || ev_dl;
    m_cl = (m_cl && !clr) || ev_cl;
  endfunction

  task automatic check_outputs();
    logic exp_sync, exp_sclk, exp_ldac;
    logic [N_CH-1:0] exp_sdo;
    bit chk_sdo;
    longint k;
    int per, j, b;
    exp_sync = 1; exp_sclk = 0; exp_ldac = 1; exp_sdo = '0; chk_sdo = m_rst_last;
    if (!m_rst_last && m_have) begin
      k = edge_n - m_s;
      per = 2 * (m_d + 1);
      if (k >= 1 && k <= m_L) begin
        j = int'(k) - 1;
        exp_sync = 0;
        exp_sclk = (j % per) > m_d;
        b = DATA_W - 1 - j / per;
        for (int c = 0; c < N_CH; c++) exp_sdo[c] = m_word[c][b];
        chk_sdo = 1;
      end
      if (m_ldac && k >= m_L + 2 && k <= m_L + 1 + LDAC_W) exp_ldac = 0;
    end
    check_val("syncn", 32'(bus.syncn_o), 32'(exp_sync));
    check_val("sclk", 32'(bus.sclk_o), 32'(exp_sclk));
    check_val("ldacn", 32'(bus.ldacn_o), 32'(exp_ldac));
    check_val("busy", 32'(bus.busy_o), 32'(model_busy()));
    check_val("data_lost", 32'(bus.data_lost_o), 32'(m_dl));
    check_val("commit_lost", 32'(bus.commit_lost_o), 32'(m_cl));
    if (chk_sdo) check_val("sdo", 32'(bus.sdo_o), 32'(exp_sdo));
  endtask

  task automatic observe();
    if (bus.syncn_o === 1'b0) begin
      if (prev_sync) begin
        frames++; t_fall = edge_n; last_gap = hi_run; lo_run = 0; t_sclk_rise = -1;
        for (int c = 0; c < N_CH; c++) cap[c] = '0;
      end
      lo_run++;
      if (bus.sclk_o === 1'b1 && !prev_sclk) begin
        for (int c = 0; c < N_CH; c++) cap[c] = {cap[c][DATA_W-2:0], bus.sdo_o[c]};
        if (t_sclk_rise >= 0) sclk_per = int'(edge_n - t_sclk_rise);
        t_sclk_rise = edge_n;
      end
    end else begin
      if (!prev_sync) begin
        last_low = lo_run; t_rise = edge_n; hi_run = 0;
        for (int c = 0; c < N_CH; c++) last_word[c] = cap[c];
      end
      hi_run++;
    end
    if (bus.ldacn_o === 1'b0) begin
      if (prev_ldac) begin ldac_pulses++; gap_ldac = edge_n - t_rise; ld_run = 0; end
      ld_run++;
    end else if (!prev_ldac) begin
      last_ld = ld_run;
    end
    prev_sync = (bus.syncn_o !== 1'b0);
    prev_sclk = (bus.sclk_o === 1'b1);
    prev_ldac = (bus.ldacn_o !== 1'b0);
  endtask

  task automatic tick(input bit wr, input logic [1:0] ch, input logic [DATA_W-1:0] data,
                      input bit commit, input bit clr, input bit rst);
    bus.wr_i = wr; bus.ch_i = ch; bus.data_i = data; bus.commit_i = commit;
    bus.clr_err_i = clr; bus.div_i = div; bus.ldac_en_i = ldac_en; rst_n = !rst;
    model_step(wr, int'(ch), data, commit, clr, rst);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    observe();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick(0, 2'd0, '0, 0, 0, 0);
  endtask

  task automatic run_idle(input int limit);
    int n = 0;
    while (model_busy() && n < limit) begin idle_n(1); n++; end
    if (model_busy()) check_val("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses0, frames0;
    longint t_commit;

    tick(0, 2'd0, '0, 0, 0, 1);
    tick(0, 2'd0, '0, 0, 0, 1);
    idle_n(2);

    // Two channels, div=1, LDAC enabled.
    div = 6'd1; ldac_en = 1;
    tick(1, 2'd0, 24'hA5A5A5, 0, 0, 0);
    tick(1, 2'd3, 24'h00000F, 0, 0, 0);
    tick(0, 2'd0, '0, 1, 0, 0);
    run_idle(400);
    idle_n(2);
    check_val("frame_len_d1", 32'(last_low), 32'd96);
    check_val("word_ch0", 32'(last_word[0]), 32'hA5A5A5);
    check_val("word_ch3", 32'(last_word[3]), 32'h00000F);
    check_val("gap_to_ldac", 32'(gap_ldac), 32'd1);
    check_val("ldac_len", 32'(last_ld), 32'd4);

    // div=0, no LDAC.
    div = 6'd0; ldac_en = 0; pulses0 = ldac_pulses;
    tick(0, 2'd0, '0, 1, 0, 0);
    t_commit = edge_n;
    run_idle(400);
    idle_n(2);
    check_val("frame_len_d0", 32'(last_low), 32'd48);
    check_val("sclk_period", 32'(sclk_per), 32'd2);
    check_val("commit_latency", 32'(t_fall - t_commit + 1), 32'd2);
    check_val("no_ldac", 32'(ldac_pulses), 32'(pulses0));

    // Overwrite before commit.
    tick(1, 2'd1, 24'h111111, 0, 0, 0);
    tick(1, 2'd1, 24'h222222, 0, 0, 0);
    check_val("dl_set", 32'(bus.data_lost_o), 32'd1);
    tick(0, 2'd0, '0, 1, 0, 0);
    run_idle(400);
    idle_n(2);
    check_val("word_ch1", 32'(last_word[1]), 32'h222222);
    tick(0, 2'd0, '0, 0, 1, 0);
    check_val("dl_clr", 32'(bus.data_lost_o), 32'd0);

    // Double commit during SHIFT.
    frames0 = frames;
    tick(0, 2'd0, '0, 1, 0, 0);
    idle_n(10);
    tick(0, 2'd0, '0, 1, 0, 0);
    idle_n(5);
    tick(0, 2'd0, '0, 1, 0, 0);
    check_val("cl_set", 32'(bus.commit_lost_o), 32'd1);
    run_idle(400);
    idle_n(2);
    check_val("b2b_frames", 32'(frames - frames0), 32'd2);
    check_val("b2b_gap", 32'(last_gap), 32'd2);

    // Reset at bit 10 of a div=1 frame.
    div = 6'd1; ldac_en = 1; pulses0 = ldac_pulses;
    tick(0, 2'd0, '0, 1, 0, 0);
    idle_n(41);
    tick(0, 2'd0, '0, 0, 0, 1);
    check_val("rst_syncn", 32'(bus.syncn_o), 32'd1);
    check_val("rst_sclk", 32'(bus.sclk_o), 32'd0);
    check_val("rst_busy", 32'(bus.busy_o), 32'd0);
    idle_n(10);
    check_val("rst_no_ldac", 32'(ldac_pulses), 32'(pulses0));
    tick(0, 2'd0, '0, 1, 0, 0);
    run_idle(400);
    idle_n(2);
    for (int c = 0; c < N_CH; c++) check_val("zero_after_rst", 32'(last_word[c]), 32'd0);

    // Same-cycle write and commit.
    tick(1, 2'd2, 24'h123456, 1, 0, 0);
    run_idle(400);
    idle_n(2);
    check_val("word_ch2", 32'(last_word[2]), 32'h123456);
    check_val("same_cycle_dl", 32'(bus.data_lost_o), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      div = DIV_W'($urandom_range(2));
      if (!model_busy() && $urandom_range(30) == 0) ldac_en = !ldac_en;
      tick($urandom_range(5) == 0, 2'($urandom_range(3)), DATA_W'($urandom),
           $urandom_range(59) == 0, $urandom_range(39) == 0, $urandom_range(799) == 0);
    end
    run_idle(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
